// File: rtl/hazard_ctrl.sv
// Fetch/IF-ID sequencer: boot hold, load-use stall, MDU stall, branch flush.
// Latency: all control outputs are combinational from state and inputs (0 cycles).
// Backpressure: PCWrite=1 holds fetch; ex_hold=1 freezes EX while the MDU works.
module hazard_ctrl #(
  parameter int BOOT_CYCLES = 4,
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             ex_br_taken,
  input  logic [31:0]      ex_br_target,
  input  logic             mdu_start,
  input  logic             mdu_done,
  input  logic             cnt_clr,
  output logic             PCWrite,
  output logic             PCSrc,
  output logic [31:0]      PCimm,
  output logic             id_ex_bubble,
  output logic             ex_hold,
  output logic [1:0]       state_o,
  output logic             mdu_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam int TW = $clog2(MDU_TIMEOUT);
  localparam logic [BW-1:0] BOOT_INIT = BW'(BOOT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(MDU_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_MDU   = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   boot_cnt_q, boot_cnt_d;
  logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic            mdu_err_q, mdu_err_d;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic            lu;
  logic            stall_inc, flush_inc;

  // Load-use: EX load writes a register the ID instruction reads (x0 never hazards).
  assign lu = ex_memread && (ex_rd != 5'd0) &&
              ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

  // State, boot/timeout counters and sticky MDU error register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_BOOT;
      boot_cnt_q <= BOOT_INIT;
      tmo_cnt_q  <= '0;
      mdu_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      mdu_err_q  <= mdu_err_d;
    end
  end

  // Next-state: branch beats MDU start in RUN; MDU exits on done or timeout.
  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    mdu_err_d  = mdu_err_q;
    case (state_q)
      S_BOOT: begin
        if (boot_cnt_q == '0) state_d = S_RUN;
        else                  boot_cnt_d = boot_cnt_q - 1'b1;
      end
      S_RUN: begin
        if (ex_br_taken) begin
          state_d = S_FLUSH;
        end else if (mdu_start) begin
          state_d   = S_MDU;
          tmo_cnt_d = '0;
        end
      end
      S_MDU: begin
        if (mdu_done) begin
          state_d = S_RUN;
        end else if (tmo_cnt_q == TMO_LAST) begin
          mdu_err_d = 1'b1;
          state_d   = S_RUN;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // Outputs: decoded combinationally from current state and this cycle's inputs.
  always_comb begin
    PCWrite      = 1'b0;
    PCSrc        = 1'b0;
    PCimm        = 32'd0;
    id_ex_bubble = 1'b0;
    ex_hold      = 1'b0;
    flush_inc    = 1'b0;
    case (state_q)
      S_BOOT: begin
        PCWrite      = 1'b1;
        id_ex_bubble = 1'b1;
      end
      S_RUN: begin
        if (ex_br_taken) begin
          PCSrc        = 1'b1;
          PCimm        = ex_br_target;
          id_ex_bubble = 1'b1;
          flush_inc    = 1'b1;
        end else if (mdu_start) begin
          PCWrite = 1'b1;
          ex_hold = 1'b1;
        end else if (lu) begin
          PCWrite      = 1'b1;
          id_ex_bubble = 1'b1;
        end
      end
      S_MDU: begin
        if (!mdu_done) begin
          PCWrite = 1'b1;
          ex_hold = 1'b1;
        end
      end
      default: id_ex_bubble = 1'b1;
    endcase
  end

  // Boot holds are not counted as stalls.
  assign stall_inc = PCWrite && ((state_q == S_RUN) || (state_q == S_MDU));

  // Saturating performance counters; clear takes priority over increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else if (cnt_clr) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_inc && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (flush_inc && (flush_q != '1)) flush_q <= flush_q + 1'b1;
    end
  end

  assign state_o      = state_q;
  assign mdu_err      = mdu_err_q;
  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

endmodule
